// File: rtl/shifter_pkg.sv
// Shared types and constants for the multi-cycle right shifter.
package shifter_pkg;

  localparam int SHR_WIDTH    = 32;
  localparam int SHR_BIG_STEP = 16;
  localparam int SHAMT_W      = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } shr_state_t;

endpackage

// File: rtl/shift_right_seq_if.sv
// Request/result bundle between the ALU control (master) and the right shifter (slave).
interface shift_right_seq_if
  import shifter_pkg::*;
#(
  parameter int WIDTH = SHR_WIDTH
);

  // Handshake: start is only taken while busy is low or done is high; a taken
  // start is followed by exactly one done pulse, with res valid in that cycle.
  logic               start;
  logic               arith;
  logic [WIDTH-1:0]   a;
  logic [SHAMT_W-1:0] shamt;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   res;
  shr_state_t         state;

  modport master (
    output start, arith, a, shamt,
    input  busy, done, res, state
  );

  modport slave (
    input  start, arith, a, shamt,
    output busy, done, res, state
  );

endinterface

// File: rtl/shift_right_step.sv
// One shifter iteration: a big (BIG_STEP-bit) or single-bit right shift with a given fill bit.
module shift_right_step #(
  parameter int WIDTH    = 32,
  parameter int BIG_STEP = 16
) (
  input  logic [WIDTH-1:0] data,
  input  logic             fill,
  input  logic             big,
  output logic [WIDTH-1:0] next_data
);

  always_comb begin
    if (big) begin
      next_data = {{BIG_STEP{fill}}, data[WIDTH-1:BIG_STEP]};
    end else begin
      next_data = {fill, data[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/shift_right_seq.sv
// Multi-cycle SRL/SRA shifter: consumes the shift amount in 16-bit steps first, then 1-bit steps.
module shift_right_seq
  import shifter_pkg::*;
#(
  parameter int WIDTH    = SHR_WIDTH,
  parameter int BIG_STEP = SHR_BIG_STEP
) (
  input  logic              clk,
  input  logic              reset,
  shift_right_seq_if.slave  bus
);

  localparam logic [SHAMT_W-1:0] BIG_REM = SHAMT_W'(BIG_STEP);

  shr_state_t         state;
  logic [WIDTH-1:0]   data;
  logic [SHAMT_W-1:0] rem;
  logic               fill;
  logic               busy_r;
  logic               done_r;
  logic [WIDTH-1:0]   res_r;

  logic               big;
  logic [SHAMT_W-1:0] rem_next;
  logic [WIDTH-1:0]   step_data;

  assign big      = (rem >= BIG_REM);
  assign rem_next = big ? (rem - BIG_REM) : (rem - SHAMT_W'(1));

  shift_right_step #(
    .WIDTH    (WIDTH),
    .BIG_STEP (BIG_STEP)
  ) u_step (
    .data      (data),
    .fill      (fill),
    .big       (big),
    .next_data (step_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      data   <= '0;
      rem    <= '0;
      fill   <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      res_r  <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        // DONE accepts a new start exactly like IDLE, so back-to-back ops skip IDLE.
        IDLE, DONE: begin
          if (bus.start) begin
            data   <= bus.a;
            rem    <= bus.shamt;
            fill   <= bus.arith & bus.a[WIDTH-1];
            busy_r <= 1'b1;
            if (bus.shamt == '0) begin
              state  <= DONE;
              done_r <= 1'b1;
              res_r  <= bus.a;
            end else begin
              state <= SHIFT;
            end
          end else begin
            state  <= IDLE;
            busy_r <= 1'b0;
          end
        end
        SHIFT: begin
          data <= step_data;
          rem  <= rem_next;
          if (rem_next == '0) begin
            state  <= DONE;
            done_r <= 1'b1;
            res_r  <= step_data;
          end
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  assign bus.res   = res_r;
  assign bus.state = state;

endmodule

// File: tb/tb_shift_right_seq.sv
// Self-checking bench for shift_right_seq: directed cases plus randomized operations against a shift model.
module tb_shift_right_seq;
  import shifter_pkg::*;

  logic clk;
  logic reset;

  shift_right_seq_if #(.WIDTH(32)) bus ();

  shift_right_seq #(.WIDTH(32), .BIG_STEP(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fails  = 0;
  logic [31:0] exp_q[$];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // reference model
  function automatic logic [31:0] ref_shift(input logic [31:0] a, input int sh, input logic ar);
    if (ar) return 32'($signed(a) >>> sh);
    return a >> sh;
  endfunction

  function automatic int ref_lat(input int sh);
    return 1 + sh / 16 + sh % 16;
  endfunction

  // driver: called at a negedge; returns at the negedge of cycle 1 after accept
  task automatic issue(input logic [31:0] a_i, input logic [4:0] sh_i, input logic ar_i);
    bus.start = 1'b1;
    bus.a     = a_i;
    bus.shamt = sh_i;
    bus.arith = ar_i;
    exp_q.push_back(ref_shift(a_i, int'(sh_i), ar_i));
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.shamt = 5'($urandom_range(0, 31));
    bus.arith = 1'($urandom_range(0, 1));
  endtask

  // waits for done starting from cycle lat0, checking busy every cycle
  task automatic wait_done(input int lat0, output int lat);
    lat = lat0;
    while (!bus.done && lat < 40) begin
      check("busy_during_op", 32'(bus.busy), 32'd1);
      @(negedge clk);
      lat++;
    end
    if (!bus.done) check("done_timeout", 32'(bus.done), 32'd1);
  endtask

  task automatic finish_op(input string tag, input int lat0, input int exp_lat);
    int lat;
    logic [31:0] exp;
    wait_done(lat0, lat);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy_at_done"}, 32'(bus.busy), 32'd1);
    exp = exp_q.pop_front();
    check({tag, "_res"}, bus.res, exp);
  endtask

  // one idle cycle after done: done drops, busy drops, res held
  task automatic idle_after(input string tag);
    logic [31:0] held;
    held = bus.res;
    @(negedge clk);
    check({tag, "_done_low"}, 32'(bus.done), 32'd0);
    check({tag, "_busy_low"}, 32'(bus.busy), 32'd0);
    check({tag, "_res_held"}, bus.res, held);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a_i, input logic [4:0] sh_i,
                        input logic ar_i);
    issue(a_i, sh_i, ar_i);
    finish_op(tag, 1, ref_lat(int'(sh_i)));
  endtask

  initial begin
    int lat;
    logic [31:0] ra;
    logic [4:0]  rs;
    logic        rar;

    reset     = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.shamt = '0;
    bus.arith = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_res", bus.res, 32'd0);
    check("reset_state", 32'(bus.state), 32'(IDLE));

    // start together with reset must be ignored
    bus.start = 1'b1;
    bus.a     = 32'h1234_5678;
    @(negedge clk);
    check("reset_wins_busy", 32'(bus.busy), 32'd0);
    bus.start = 1'b0;
    reset     = 1'b0;
    @(negedge clk);

    // directed cases
    run_op("srl4", 32'h8000_0000, 5'd4, 1'b0);
    idle_after("srl4");
    run_op("sra31", 32'h8000_0000, 5'd31, 1'b1);
    idle_after("sra31");
    run_op("srl16", 32'hABCD_1234, 5'd16, 1'b0);
    idle_after("srl16");
    run_op("srl17", 32'hABCD_1234, 5'd17, 1'b0);
    idle_after("srl17");
    run_op("sh0", 32'hDEAD_BEEF, 5'd0, 1'b1);
    idle_after("sh0");
    run_op("sra_pos", 32'h7000_0000, 5'd20, 1'b1);
    idle_after("sra_pos");

    // start during SHIFT is ignored, then back-to-back start in DONE
    issue(32'hF0F0_1234, 5'd10, 1'b1);
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 32'h0000_0001;
    bus.shamt = 5'd0;
    @(negedge clk);
    bus.start = 1'b0;
    finish_op("ignore_start", 4, ref_lat(10));
    issue(32'h0000_F000, 5'd12, 1'b0);
    finish_op("back2back", 1, 13);
    idle_after("back2back");

    // reset during cycle 3 of a 10-step shift
    issue(32'hCAFE_BABE, 5'd10, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_busy", 32'(bus.busy), 32'd0);
    check("midreset_done", 32'(bus.done), 32'd0);
    check("midreset_res", bus.res, 32'd0);
    reset = 1'b0;
    void'(exp_q.pop_back());
    @(negedge clk);
    run_op("after_reset", 32'h8765_4321, 5'd9, 1'b1);
    idle_after("after_reset");

    // randomized operations, some back-to-back
    for (int i = 0; i < 60; i++) begin
      ra  = $urandom;
      rs  = 5'($urandom_range(0, 31));
      rar = 1'($urandom_range(0, 1));
      run_op("rand", ra, rs, rar);
      if ($urandom_range(0, 2) != 0) idle_after("rand");
    end
    idle_after("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
